// File: rtl/async_transceiver.sv
// 8N1 UART transmitter and receiver sharing one clock, with independent TX and RX paths.
// Optional macro ASYNC_TRANSCEIVER_FRAME_ERR_EN adds the RxD_frame_error pulse output.
module async_transceiver #(
    parameter int ClkFrequency = 70_000_000,
    parameter int Baud         = 115200
) (
    input  logic       clk,
    input  logic       rst,
    output logic       TxD,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD_busy,
    input  logic       RxD,
    output logic       RxD_data_ready,
    input  logic       RxD_clear,
    output logic [7:0] RxD_data
`ifdef ASYNC_TRANSCEIVER_FRAME_ERR_EN
    ,
    output logic       RxD_frame_error
`endif
);

    localparam int BIT_CYC = (ClkFrequency + Baud / 2) / Baud;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CNT_W   = $clog2(BIT_CYC);

    generate
        if (ClkFrequency < 8 * Baud) begin : g_bad_rate
            $error("async_transceiver: ClkFrequency must be at least 8*Baud");
        end
    endgenerate

    // Transmitter: the whole frame {stop, data, start} shifts out LSB first; ones refill from the top
    logic [9:0]       tx_frame_q, tx_frame_d;
    logic             tx_busy_q, tx_busy_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

    always_comb begin
        tx_frame_d = tx_frame_q;
        tx_busy_d  = tx_busy_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        if (!tx_busy_q) begin
            if (TxD_start) begin
                tx_frame_d = {1'b1, TxD_data, 1'b0};
                tx_busy_d  = 1'b1;
                tx_bit_d   = 4'd0;
                tx_cnt_d   = '0;
            end
        end else if (tx_cnt_q == CNT_W'(BIT_CYC - 1)) begin
            tx_cnt_d   = '0;
            tx_frame_d = {1'b1, tx_frame_q[9:1]};
            if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
            else                  tx_bit_d  = tx_bit_q + 4'd1;
        end else begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_frame_q <= '1;
            tx_busy_q  <= 1'b0;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= '0;
        end else begin
            tx_frame_q <= tx_frame_d;
            tx_busy_q  <= tx_busy_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    assign TxD      = tx_frame_q[0];
    assign TxD_busy = tx_busy_q;

    // Receiver
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [1:0]       rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_err_wait_q, rx_err_wait_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             rxd_s;
    logic             rx_done;

    assign rxd_s = rx_sync_q[1];

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_sync_d     = {rx_sync_q[0], RxD};
        rx_prev_d     = rxd_s;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_err_wait_d = rx_err_wait_q;
        rx_done       = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rxd_s) rx_state_d = START;
            end
            START: begin
                if (rx_cnt_q == CNT_W'(HALF - 1)) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    rx_state_d = rxd_s ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (rx_cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // After a framing error, hold here until the line is idle again
                if (rx_err_wait_q) begin
                    if (rxd_s) begin
                        rx_err_wait_d = 1'b0;
                        rx_state_d    = IDLE;
                    end
                end else if (rx_cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    rx_cnt_d = '0;
                    if (rxd_s) begin
                        rx_done    = 1'b1;
                        rx_state_d = IDLE;
                    end else begin
                        rx_err_wait_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase

        // A completing byte beats a simultaneous clear
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        if (RxD_clear) rx_ready_d = 1'b0;
        if (rx_done) begin
            rx_ready_d = 1'b1;
            rx_data_d  = rx_shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= IDLE;
            rx_sync_q     <= 2'b11;
            rx_prev_q     <= 1'b1;
            rx_cnt_q      <= '0;
            rx_bit_q      <= 3'd0;
            rx_shift_q    <= 8'h00;
            rx_err_wait_q <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_ready_q    <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_sync_q     <= rx_sync_d;
            rx_prev_q     <= rx_prev_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_err_wait_q <= rx_err_wait_d;
            rx_data_q     <= rx_data_d;
            rx_ready_q    <= rx_ready_d;
        end
    end

    assign RxD_data       = rx_data_q;
    assign RxD_data_ready = rx_ready_q;

`ifdef ASYNC_TRANSCEIVER_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // The error-wait flag rises exactly once per bad stop bit
    assign frame_err_d = rx_err_wait_d & ~rx_err_wait_q;

    always_ff @(posedge clk) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= frame_err_d;
    end

    assign RxD_frame_error = frame_err_q;
`endif

endmodule

// File: tb/tb_async_transceiver.sv
// Self-checking bench for async_transceiver at 1 MHz / 100 kbaud (10 clocks per bit),
// comparing against frame-level expectations built from the 8N1 rules.
module tb_async_transceiver;

    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int BIT_CYC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       TxD_start = 1'b0;
    logic [7:0] TxD_data = 8'h00;
    logic       RxD_clear = 1'b0;
    logic       rxd_drv = 1'b1;
    logic       loop = 1'b0;
    logic       TxD, TxD_busy, RxD_data_ready;
    logic [7:0] RxD_data;
    logic       rxd_w;

    int n_checks = 0;
    int n_pass   = 0;
    int ferr_cnt = 0;

    assign rxd_w = loop ? TxD : rxd_drv;

    always #5 clk = ~clk;

`ifdef ASYNC_TRANSCEIVER_FRAME_ERR_EN
    logic RxD_frame_error;
    always @(negedge clk) if (RxD_frame_error === 1'b1) ferr_cnt++;
`endif

    async_transceiver #(.ClkFrequency(CLK_HZ), .Baud(BAUD)) dut (
        .clk            (clk),
        .rst            (rst),
        .TxD            (TxD),
        .TxD_start      (TxD_start),
        .TxD_data       (TxD_data),
        .TxD_busy       (TxD_busy),
        .RxD            (rxd_w),
        .RxD_data_ready (RxD_data_ready),
        .RxD_clear      (RxD_clear),
        .RxD_data       (RxD_data)
`ifdef ASYNC_TRANSCEIVER_FRAME_ERR_EN
        ,
        .RxD_frame_error(RxD_frame_error)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Line level of frame bit i (0 = start, 1..8 = data LSB first, 9 = stop)
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return d[i-1];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Request one frame and watch the line for 130 cycles; optionally re-request while busy
    task automatic tx_frame(input logic [7:0] d, input bit poke,
                            output int busy_cyc, output int bad_tx,
                            output int bad_busy, output logic [9:0] mid);
        @(negedge clk);
        TxD_start = 1'b1;
        TxD_data  = d;
        @(negedge clk);
        TxD_start = 1'b0;
        TxD_data  = 8'($urandom);
        busy_cyc = 0; bad_tx = 0; bad_busy = 0; mid = '0;
        for (int c = 0; c < 130; c++) begin
            if (c < 10 * BIT_CYC) begin
                if (TxD !== frame_bit(d, c / BIT_CYC)) bad_tx++;
                if (c % BIT_CYC == BIT_CYC / 2) mid[c / BIT_CYC] = TxD;
            end else if (TxD !== 1'b1) begin
                bad_tx++;
            end
            if (TxD_busy !== (c < 10 * BIT_CYC)) bad_busy++;
            if (TxD_busy === 1'b1) busy_cyc++;
            if (poke && c == 30) begin
                TxD_start = 1'b1;
                TxD_data  = ~d;
            end else begin
                TxD_start = 1'b0;
            end
            @(negedge clk);
        end
        TxD_start = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop);
        for (int i = 0; i < 10; i++) begin
            rxd_drv = (i == 9) ? stop : frame_bit(d, i);
            tick(BIT_CYC);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        RxD_clear = 1'b1;
        @(negedge clk);
        RxD_clear = 1'b0;
    endtask

    initial begin
        int busy_cyc, bad_tx, bad_busy;
        logic [9:0] mid;
        logic [9:0] exp_seq;
        logic [7:0] d, d2, last;
        bit seen;

        // Reset values
        tick(3);
        check("rst_txd", TxD, 1'b1);
        check("rst_busy", TxD_busy, 1'b0);
        check("rst_ready", RxD_data_ready, 1'b0);
        check("rst_data", RxD_data, 8'h00);
        rst = 1'b0;
        tick(2);

        // 0xA5 waveform against the literal line sequence 0,1,0,1,0,0,1,0,1,1
        exp_seq = 10'b1101001010;
        tx_frame(8'hA5, 1'b0, busy_cyc, bad_tx, bad_busy, mid);
        for (int i = 0; i < 10; i++) check($sformatf("a5_bit%0d", i), mid[i], exp_seq[i]);
        check("a5_busy_cycles", busy_cyc, 100);
        check("a5_bad_tx", bad_tx, 0);
        check("a5_bad_busy", bad_busy, 0);

        // Loopback with a second request during busy that must be ignored
        loop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            if (k == 0) d = 8'h3C;
            tx_frame(d, 1'b1, busy_cyc, bad_tx, bad_busy, mid);
            check("loop_busy_cycles", busy_cyc, 100);
            check("loop_bad_tx", bad_tx, 0);
            check("loop_bad_busy", bad_busy, 0);
            check("loop_ready", RxD_data_ready, 1'b1);
            check("loop_data", RxD_data, d);
            pulse_clear();
            check("loop_cleared", RxD_data_ready, 1'b0);
        end
        loop = 1'b0;
        tick(5);

        // Short glitch must not produce a byte; the receiver must still accept the next frame
        rxd_drv = 1'b0;
        tick(3);
        rxd_drv = 1'b1;
        tick(30);
        check("glitch_ready", RxD_data_ready, 1'b0);
        d = 8'($urandom);
        rx_send(d, 1'b1);
        tick(20);
        check("post_glitch_ready", RxD_data_ready, 1'b1);
        check("post_glitch_data", RxD_data, d);
        last = d;
        pulse_clear();

        // Framing error: byte dropped, data unchanged
        ferr_cnt = 0;
        rx_send(8'h55, 1'b0);
        tick(30);
        check("ferr_ready", RxD_data_ready, 1'b0);
        check("ferr_data", RxD_data, last);
`ifdef ASYNC_TRANSCEIVER_FRAME_ERR_EN
        check("ferr_pulses", ferr_cnt, 1);
`endif
        d = 8'($urandom);
        rx_send(d, 1'b1);
        tick(20);
        check("post_ferr_data", RxD_data, d);
        check("post_ferr_ready", RxD_data_ready, 1'b1);
        pulse_clear();

        // 0x11 then 0x22 with clear held across the completion of 0x22
        rx_send(8'h11, 1'b1);
        tick(20);
        check("b11_ready", RxD_data_ready, 1'b1);
        check("b11_data", RxD_data, 8'h11);
        for (int i = 0; i < 9; i++) begin
            rxd_drv = frame_bit(8'h22, i);
            tick(BIT_CYC);
        end
        rxd_drv   = 1'b1;
        RxD_clear = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (RxD_data === 8'h22) seen = 1'b1;
        end
        RxD_clear = 1'b0;
        check("race_seen", seen, 1'b1);
        check("race_ready", RxD_data_ready, 1'b1);
        @(negedge clk);
        check("race_ready_hold", RxD_data_ready, 1'b1);
        check("race_data", RxD_data, 8'h22);
        tick(5);
        pulse_clear();
        check("late_clear", RxD_data_ready, 1'b0);

        // Simultaneous, independent TX and RX
        d  = 8'($urandom);
        d2 = 8'($urandom);
        fork
            tx_frame(d, 1'b0, busy_cyc, bad_tx, bad_busy, mid);
            rx_send(d2, 1'b1);
        join
        tick(5);
        check("dual_bad_tx", bad_tx, 0);
        check("dual_busy_cycles", busy_cyc, 100);
        check("dual_rx_data", RxD_data, d2);
        check("dual_rx_ready", RxD_data_ready, 1'b1);
        pulse_clear();

        // Reset in the middle of a looped-back 0xFF frame
        loop = 1'b1;
        @(negedge clk);
        TxD_start = 1'b1;
        TxD_data  = 8'hFF;
        @(negedge clk);
        TxD_start = 1'b0;
        tick(4 * BIT_CYC + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_txd", TxD, 1'b1);
        check("midrst_busy", TxD_busy, 1'b0);
        check("midrst_ready", RxD_data_ready, 1'b0);
        check("midrst_data", RxD_data, 8'h00);
        tick(200);
        check("midrst_no_byte", RxD_data_ready, 1'b0);
        check("midrst_idle_busy", TxD_busy, 1'b0);
        check("midrst_idle_txd", TxD, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
